pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Measures an incoming PWM waveform and reports its period and high time in clk cycles.
- It is the receive-side counterpart of the ax_pwm generator: it reads back the pulse trains that block produces, for example loopback checking of buzzer/LED drive.
- It also measures external PWM sources.
- Each completed period yields a one-cycle result strobe. A missing edge produces a timeout/stuck-level report.

Parameters:
- N, 32, width of the period and high-time counters and outputs.
- TIMEOUT, 50_000_000, clk cycles without a qualifying edge before a timeout is declared. Must satisfy 2 <= TIMEOUT < 2^N - 1.
- FILTER_LEN, 4, cycles the input must be stable before a level change is accepted. Used only with PWM_CAPTURE_FILTER_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-high.
- pwm_in  in  1  asynchronous PWM input.
- period  out  N  cycles between the last two accepted rising edges.
- high_time  out  N  cycles from the last accepted rising edge to the following falling edge.
- valid  out  1  one-cycle strobe; period/high_time were updated this cycle.
- timeout  out  1  sticky flag: no edge seen within TIMEOUT. Cleared by the next valid.
- stuck_level  out  1  input level when timeout was declared.

Behaviour:
- One clock; reset is asynchronous and active-high on rst. All state is in the clk domain.
- Input conditioning:
  - pwm_in passes through a 2-flop synchronizer, then a 1-flop history register.
  - rise = sync & ~hist; fall = ~sync & hist.
  - Edge-to-detection latency: 3 clk cycles, constant, so measured durations are exact.
- Reset values: period=0, high_time=0, valid=0, timeout=0, stuck_level=0, state=IDLE, counters=0, sync/hist flops=0.
- State machine:
  - IDLE: wait for rise. On rise, go to HIGH with cnt=1; no output.
  - HIGH: cnt increments each cycle.
    - On fall: hi_lat=cnt, go to LOW, cnt keeps counting.
    - If cnt reaches TIMEOUT: go to IDLE; timeout=1, stuck_level=1, period=0, high_time=0.
  - LOW: cnt increments.
    - On rise: period=cnt, high_time=hi_lat, valid=1 for that cycle, timeout=0; cnt restarts at 1; stay in HIGH (next state HIGH).
    - If cnt reaches TIMEOUT: go to IDLE; timeout=1, stuck_level=0, period=0, high_time=0.
- Counting rule: cnt is the number of clk cycles since the rising edge, including the rise cycle. An input high for H cycles and low for L cycles gives period=H+L and high_time=H.
- Timeout check precedes edge check in the same cycle only when cnt==TIMEOUT. An edge arriving exactly when cnt==TIMEOUT is treated as a timeout; the block then resynchronizes from IDLE on the next rise.
- cnt never exceeds TIMEOUT, so no wrap is possible.
- Simultaneous rise and fall cannot occur (single-bit history).
- A fall seen in IDLE is ignored.
- period/high_time hold their last values between valid strobes.
- Reset mid-measurement discards the partial period. The first valid after reset requires two full rising edges.
- 0% and 100% duty inputs are reported only via timeout/stuck_level, never via valid.

Optional Feature:
- Macro PWM_CAPTURE_FILTER_EN.
- Defined:
  - The synchronized input feeds a glitch filter. The filtered level changes only after the raw synchronized level has differed from it for FILTER_LEN consecutive cycles.
  - Edge detection operates on the filtered level.
  - Latency becomes 3+FILTER_LEN cycles, equal for both edges, so measured durations stay exact for pulses >= FILTER_LEN.
  - Shorter pulses are suppressed.
- Undefined: no filter; any pulse >= 1 synchronized cycle is an edge.

Decomposition:
- Package pwm_capture_pkg:
  - state encoding constants (IDLE=2'd0, HIGH=2'd1, LOW=2'd2);
  - default N and TIMEOUT constants.
- One sub-module, pwm_capture_edge: synchronizer, optional filter, history flop, and rise/fall outputs.
- The FSM, counters and output registers stay in pwm_capture.

Test Plan:
- Steady PWM, high 3 / low 7 cycles, repeated 5 periods → after the second rise, valid pulses once per 10 cycles with period=10, high_time=3; timeout=0.
- pwm_in held at 1 after one rise, TIMEOUT=100 → timeout=1, stuck_level=1, period=0, high_time=0 at cnt==100. A later square wave of high 5 / low 5 → valid with period=10, high_time=5, timeout cleared.
- pwm_in held at 0 after a complete period, TIMEOUT=100 → timeout=1, stuck_level=0.
- Assert rst for 2 cycles in the middle of a HIGH phase → all outputs 0 immediately (asynchronous). No valid until two new rises are seen.
- Duty sweep using ax_pwm with N=32, period=8590: duty steps of 10% of 2^32 → high_time reported within ±1 cycle of the expected value, period matching the generated cycle length.
- PWM_CAPTURE_FILTER_EN, FILTER_LEN=4: 2-cycle glitch inside the low phase of a high 20 / low 20 wave → no extra valid; period=40, high_time=20. Without the macro, the same stimulus yields a short period report.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared state encoding and default sizes for pwm_capture
package pwm_capture_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  // Default configuration
  localparam int DEFAULT_N          = 32;
  localparam int DEFAULT_TIMEOUT    = 50_000_000;
  localparam int DEFAULT_FILTER_LEN = 4;

endpackage

// File: rtl/pwm_capture_edge.sv
// rtl/pwm_capture_edge.sv - pwm_in synchronizer, optional glitch filter (PWM_CAPTURE_FILTER_EN), edge detect
module pwm_capture_edge
  import pwm_capture_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q, hist_d;
  logic level;

  // Two-flop synchronizer feeding the edge detector
  always_comb begin
    sync1_d = pwm_in;
    sync2_d = sync1_q;
  end

  // Synchronizer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);

  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;

  // Accept a new level only after it has disagreed with the filtered level
  // for FILTER_LEN consecutive cycles; both edges see the same extra delay.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Filter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign level = filt_q;
`else
  logic [31:0] filter_len_unused;
  assign filter_len_unused = FILTER_LEN;
  assign level = sync2_q;
`endif

  // History flop holds the previous conditioned level
  always_comb begin
    hist_d = level;
  end

  // History register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign rise = level & ~hist_q;
  assign fall = ~level & hist_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time capture with timeout; glitch filter under PWM_CAPTURE_FILTER_EN
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int N          = DEFAULT_N,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm_in,
  output logic [N-1:0] period,
  output logic [N-1:0] high_time,
  output logic         valid,
  output logic         timeout,
  output logic         stuck_level
);

  localparam logic [N-1:0] TIMEOUT_C = N'(TIMEOUT);
  localparam logic [N-1:0] ONE       = N'(1);

  logic rise, fall;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] hi_lat_q, hi_lat_d;
  logic [N-1:0] period_q, period_d;
  logic [N-1:0] high_time_q, high_time_d;
  logic         valid_q, valid_d;
  logic         timeout_q, timeout_d;
  logic         stuck_q, stuck_d;

  pwm_capture_edge #(
    .FILTER_LEN(FILTER_LEN)
  ) u_edge (
    .clk   (clk),
    .rst   (rst),
    .pwm_in(pwm_in),
    .rise  (rise),
    .fall  (fall)
  );

  // Measurement FSM: cnt counts cycles since the accepted rise (rise cycle
  // included). The timeout check wins over an edge arriving at cnt==TIMEOUT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_lat_d    = hi_lat_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;
    stuck_d     = stuck_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = ONE;
        end
      end
      HIGH: begin
        if (cnt_q == TIMEOUT_C) begin
          state_d     = IDLE;
          cnt_d       = '0;
          timeout_d   = 1'b1;
          stuck_d     = 1'b1;
          period_d    = '0;
          high_time_d = '0;
        end else begin
          cnt_d = cnt_q + ONE;
          if (fall) begin
            hi_lat_d = cnt_q;
            state_d  = LOW;
          end
        end
      end
      LOW: begin
        if (cnt_q == TIMEOUT_C) begin
          state_d     = IDLE;
          cnt_d       = '0;
          timeout_d   = 1'b1;
          stuck_d     = 1'b0;
          period_d    = '0;
          high_time_d = '0;
        end else if (rise) begin
          period_d    = cnt_q;
          high_time_d = hi_lat_q;
          valid_d     = 1'b1;
          timeout_d   = 1'b0;
          cnt_d       = ONE;
          state_d     = HIGH;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_lat_q    <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      stuck_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_lat_q    <= hi_lat_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      stuck_q     <= stuck_d;
    end
  end

  assign period      = period_q;
  assign high_time   = high_time_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - randomized and directed bench for pwm_capture against a timestamp model
module tb_pwm_capture;

  localparam int N       = 32;
  localparam int TIMEOUT = 100;
  localparam int FL      = 4;
  localparam int MAXC    = 16384;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int D = 4;
`else
  localparam int D = 3;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pwm_in = 1'b0;
  logic [N-1:0] period, high_time;
  logic         valid, timeout, stuck_level;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int dut_valid_cnt = 0;

  // expected outputs indexed by the cycle they must appear on
  bit         exp_valid   [MAXC];
  bit         exp_timeout [MAXC];
  bit         exp_stuck   [MAXC];
  bit [N-1:0] exp_period  [MAXC];
  bit [N-1:0] exp_high    [MAXC];

  // model: timestamps of accepted edges in the conditioned-level domain
  bit         m_prev, m_armed, m_seen_fall, m_timeout, m_stuck, m_filt;
  int         m_t_rise, m_t_fall, m_run;
  bit [N-1:0] m_period, m_high;

  pwm_capture #(
    .N         (N),
    .TIMEOUT   (TIMEOUT),
    .FILTER_LEN(FL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .period     (period),
    .high_time  (high_time),
    .valid      (valid),
    .timeout    (timeout),
    .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic put_exp(input int idx, input bit v);
    exp_valid[idx]   = v;
    exp_timeout[idx] = m_timeout;
    exp_stuck[idx]   = m_stuck;
    exp_period[idx]  = m_period;
    exp_high[idx]    = m_high;
  endtask

  task automatic model_step(input int k, input bit r, input bit lvl);
    bit lv, ev_rise, ev_fall, v;
    if (k + D >= MAXC) begin
      $display("FAIL cycle_budget: cycle %0d exceeds limit %0d", k, MAXC - D);
      $fatal(1, "cycle budget exceeded");
    end
    if (r) begin
      m_prev = 0; m_armed = 0; m_seen_fall = 0; m_timeout = 0; m_stuck = 0;
      m_filt = 0; m_run = 0; m_period = 0; m_high = 0;
      for (int i = 0; i <= D; i++) put_exp(k + i, 1'b0);
      return;
    end
`ifdef PWM_CAPTURE_FILTER_EN
    if (lvl != m_filt) begin
      m_run++;
      if (m_run == FL) begin
        m_filt = lvl;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
    lv = m_filt;
`else
    lv = lvl;
`endif
    ev_rise = lv & ~m_prev;
    ev_fall = ~lv & m_prev;
    m_prev  = lv;
    v = 1'b0;
    if (m_armed && (k - m_t_rise) == TIMEOUT) begin
      m_timeout = 1; m_stuck = ~m_seen_fall; m_period = 0; m_high = 0; m_armed = 0;
    end else if (ev_rise) begin
      if (m_armed) begin
        m_period  = N'(k - m_t_rise);
        m_high    = N'(m_t_fall - m_t_rise);
        m_timeout = 0;
        v = 1'b1;
      end
      m_armed = 1; m_t_rise = k; m_seen_fall = 0;
    end else if (ev_fall && m_armed && !m_seen_fall) begin
      m_seen_fall = 1; m_t_fall = k;
    end
    put_exp(k + D, v);
  endtask

  task automatic drive(input bit lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst    = 1'b0;
      pwm_in = lvl;
      model_step(cyc, 1'b0, lvl);
    end
  endtask

  task automatic check_lit(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, expv);
    end
  endtask

  task automatic do_reset(input int n, input bit chk);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_step(cyc, 1'b1, pwm_in);
      if (chk && i == 0) begin
        #1;
        check_lit("rst_async_period", period, 0);
        check_lit("rst_async_high", high_time, 0);
        check_lit("rst_async_timeout", {31'd0, timeout}, 0);
      end
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      n_tests++;
      if (valid !== exp_valid[cyc] || timeout !== exp_timeout[cyc] ||
          stuck_level !== exp_stuck[cyc] || period !== exp_period[cyc] ||
          high_time !== exp_high[cyc]) begin
        n_fail++;
        $display("FAIL cycle%0d outputs: got v=%0b to=%0b st=%0b per=%0d hi=%0d, want v=%0b to=%0b st=%0b per=%0d hi=%0d",
                 cyc, valid, timeout, stuck_level, period, high_time,
                 exp_valid[cyc], exp_timeout[cyc], exp_stuck[cyc], exp_period[cyc], exp_high[cyc]);
      end
      if (valid === 1'b1) dut_valid_cnt++;
    end
  end

  initial begin
    do_reset(3, 1'b0);
    drive(0, 5);

    // steady 3/7 wave, five periods
    dut_valid_cnt = 0;
    for (int p = 0; p < 5; p++) begin
      drive(1, 3);
      drive(0, 7);
    end
`ifndef PWM_CAPTURE_FILTER_EN
    check_lit("wave37_valid_count", dut_valid_cnt, 4);
    check_lit("wave37_period", period, 10);
    check_lit("wave37_high", high_time, 3);
    check_lit("wave37_timeout", {31'd0, timeout}, 0);
`endif

    // stuck high
    drive(1, 150);
    check_lit("stuck_hi_timeout", {31'd0, timeout}, 1);
    check_lit("stuck_hi_level", {31'd0, stuck_level}, 1);
    check_lit("stuck_hi_period", period, 0);
    check_lit("stuck_hi_high", high_time, 0);

    // recovery with 5/5 wave
    drive(0, 5);
    for (int p = 0; p < 4; p++) begin
      drive(1, 5);
      drive(0, 5);
    end
    check_lit("wave55_period", period, 10);
    check_lit("wave55_high", high_time, 5);
    check_lit("wave55_timeout", {31'd0, timeout}, 0);

    // stuck low
    drive(0, 150);
    check_lit("stuck_lo_timeout", {31'd0, timeout}, 1);
    check_lit("stuck_lo_level", {31'd0, stuck_level}, 0);

    // reset in the middle of a high phase
    for (int p = 0; p < 3; p++) begin
      drive(1, 4);
      drive(0, 6);
    end
    drive(1, 3);
    do_reset(2, 1'b1);
    dut_valid_cnt = 0;
    drive(1, 5);
    drive(0, 6);
    check_lit("post_rst_no_valid", dut_valid_cnt, 0);
    drive(1, 4);
    drive(0, 6);
    check_lit("post_rst_valid_count", dut_valid_cnt, 1);
    check_lit("post_rst_period", period, 11);
    check_lit("post_rst_high", high_time, 5);

    // longest measurable period, then a rise exactly at cnt==TIMEOUT
    drive(1, 50);
    drive(0, 49);
    drive(1, 50);
    check_lit("edge99_period", period, 99);
    check_lit("edge99_high", high_time, 50);
    drive(0, 50);
    drive(1, 10);
    check_lit("edge100_timeout", {31'd0, timeout}, 1);
    check_lit("edge100_level", {31'd0, stuck_level}, 0);
    check_lit("edge100_period", period, 0);

    // duty sweep, period 90
    for (int d = 1; d <= 9; d++) begin
      drive(1, 9 * d);
      drive(0, 90 - 9 * d);
    end
    check_lit("sweep_period", period, 90);
    check_lit("sweep_high", high_time, 72);

    // random waveform, occasionally near the timeout boundary
    for (int p = 0; p < 40; p++) begin
      int h, l;
      h = ($urandom_range(7, 0) == 0) ? int'($urandom_range(105, 95)) : int'($urandom_range(40, 1));
      l = ($urandom_range(7, 0) == 0) ? int'($urandom_range(105, 95)) : int'($urandom_range(40, 1));
      drive(1, h);
      drive(0, l);
    end

    // 2-cycle glitch inside the low phase of a 20/20 wave
    drive(0, 30);
    for (int p = 0; p < 2; p++) begin
      drive(1, 20);
      drive(0, 9);
      drive(1, 2);
      drive(0, 9);
    end
    drive(1, 20);
    drive(0, 20);
`ifdef PWM_CAPTURE_FILTER_EN
    check_lit("glitch_period", period, 40);
    check_lit("glitch_high", high_time, 20);
`else
    check_lit("glitch_period", period, 11);
    check_lit("glitch_high", high_time, 2);
`endif
    drive(0, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
